// File: rtl/me_frame_scheduler.sv
// Frame-level sequencer for the hexagon-search motion-estimation engine: walks 16x16
// macroblocks in raster order, runs the engine start/done handshake, queues results in a FWFT FIFO.
module me_frame_scheduler #(
  parameter int unsigned WIDTH      = 352,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IDX_W      = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_go,
  input  logic             abort,
  input  logic [31:0]      frame_start_addr,
  input  logic [31:0]      ref_start_addr,
  output logic             me_start,
  output logic [31:0]      me_mb_x,
  output logic [31:0]      me_mb_y,
  output logic [31:0]      me_frame_addr,
  output logic [31:0]      me_ref_addr,
  input  logic             me_done,
  input  logic [5:0]       me_mv_x,
  input  logic [5:0]       me_mv_y,
  input  logic [15:0]      me_sad,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [IDX_W-1:0] res_mb_idx,
  output logic [5:0]       res_mv_x,
  output logic [5:0]       res_mv_y,
  output logic [15:0]      res_sad,
  output logic             busy,
  output logic             frame_done,
  output logic [IDX_W-1:0] mb_count
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntW = IDX_W + 28;
  localparam logic [31:0] LastX = 32'(WIDTH - 16);
  localparam logic [31:0] LastY = 32'(HEIGHT - 16);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StIssue   = 3'd1;
  localparam logic [2:0] StRelease = 3'd2;
  localparam logic [2:0] StFinish  = 3'd3;
  localparam logic [2:0] StDrain   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             me_start_q, me_start_d;
  logic [31:0]      mb_x_q, mb_x_d, mb_y_q, mb_y_d;
  logic [31:0]      frame_addr_q, frame_addr_d, ref_addr_q, ref_addr_d;
  logic [IDX_W-1:0] mb_idx_q, mb_idx_d, mb_count_q, mb_count_d;
  logic             rel_wait_q, rel_wait_d;
  logic             frame_done_q, frame_done_d;

  logic [EntW-1:0]  mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push, pop, fifo_full, fifo_empty;
  logic [EntW-1:0]  head;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Push uses registered full only; a same-cycle pop does not make room.
  assign pop        = !fifo_empty && res_ready;

  always_comb begin
    state_d      = state_q;
    me_start_d   = me_start_q;
    mb_x_d       = mb_x_q;
    mb_y_d       = mb_y_q;
    frame_addr_d = frame_addr_q;
    ref_addr_d   = ref_addr_q;
    mb_idx_d     = mb_idx_q;
    mb_count_d   = mb_count_q;
    rel_wait_d   = rel_wait_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    if (state_q != StIdle && state_q != StDrain && abort) begin
      // Abort wins over any push or completion this cycle.
      me_start_d = 1'b0;
      state_d    = StDrain;
    end else begin
      case (state_q)
        StIdle: begin
          if (frame_go) begin
            frame_addr_d = frame_start_addr;
            ref_addr_d   = ref_start_addr;
            mb_x_d       = '0;
            mb_y_d       = '0;
            mb_idx_d     = '0;
            mb_count_d   = '0;
            me_start_d   = 1'b1;
            state_d      = StIssue;
          end
        end
        StIssue: begin
          if (me_done && !fifo_full) begin
            push       = 1'b1;
            me_start_d = 1'b0;
            mb_count_d = mb_count_q + 1'b1;
            rel_wait_d = 1'b1;
            state_d    = StRelease;
          end
        end
        StRelease: begin
          // First RELEASE cycle is unconditional so me_start stays low at least two cycles.
          if (rel_wait_q) begin
            rel_wait_d = 1'b0;
          end else if (!me_done) begin
            if (mb_x_q == LastX && mb_y_q == LastY) begin
              state_d = StFinish;
            end else begin
              if (mb_x_q == LastX) begin
                mb_x_d = '0;
                mb_y_d = mb_y_q + 32'd16;
              end else begin
                mb_x_d = mb_x_q + 32'd16;
              end
              mb_idx_d   = mb_idx_q + 1'b1;
              me_start_d = 1'b1;
              state_d    = StIssue;
            end
          end
        end
        StFinish: begin
          if (fifo_empty) begin
            frame_done_d = 1'b1;
            state_d      = StIdle;
          end
        end
        StDrain: begin
          if (!me_done) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      me_start_q   <= 1'b0;
      mb_x_q       <= '0;
      mb_y_q       <= '0;
      frame_addr_q <= '0;
      ref_addr_q   <= '0;
      mb_idx_q     <= '0;
      mb_count_q   <= '0;
      rel_wait_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      me_start_q   <= me_start_d;
      mb_x_q       <= mb_x_d;
      mb_y_q       <= mb_y_d;
      frame_addr_q <= frame_addr_d;
      ref_addr_q   <= ref_addr_d;
      mb_idx_q     <= mb_idx_d;
      mb_count_q   <= mb_count_d;
      rel_wait_q   <= rel_wait_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {mb_idx_q, me_mv_x, me_mv_y, me_sad};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head          = mem_q[rd_ptr_q];
  assign res_valid     = !fifo_empty;
  assign res_mb_idx    = head[EntW-1 -: IDX_W];
  assign res_mv_x      = head[27:22];
  assign res_mv_y      = head[21:16];
  assign res_sad       = head[15:0];
  assign me_start      = me_start_q;
  assign me_mb_x       = mb_x_q;
  assign me_mb_y       = mb_y_q;
  assign me_frame_addr = frame_addr_q;
  assign me_ref_addr   = ref_addr_q;
  assign busy          = (state_q != StIdle);
  assign frame_done    = frame_done_q;
  assign mb_count      = mb_count_q;

endmodule

// File: tb/tb_me_frame_scheduler.sv
// Directed bench for me_frame_scheduler on a 48x32 frame (6 macroblocks) with a 4-deep FIFO,
// driven by a small engine model whose done latency and release hold are adjustable.
module tb_me_frame_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_go = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] frame_start_addr = '0;
  logic [31:0] ref_start_addr = '0;
  logic        me_start;
  logic [31:0] me_mb_x, me_mb_y, me_frame_addr, me_ref_addr;
  logic        me_done;
  logic [5:0]  me_mv_x, me_mv_y;
  logic [15:0] me_sad;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [8:0]  res_mb_idx;
  logic [5:0]  res_mv_x, res_mv_y;
  logic [15:0] res_sad;
  logic        busy, frame_done;
  logic [8:0]  mb_count;

  int checks = 0;
  int errors = 0;
  int hold_cfg = 0;

  logic [36:0] pops[$];
  logic [31:0] starts[$];
  int fd_cnt = 0, pops_at_done = 0, viol = 0, min_gap = 1000, gap = 1000;
  logic prev_start = 1'b0, prev_done = 1'b0;

  me_frame_scheduler #(
    .WIDTH(48), .HEIGHT(32), .FIFO_DEPTH(4), .IDX_W(9)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_go(frame_go), .abort(abort),
    .frame_start_addr(frame_start_addr), .ref_start_addr(ref_start_addr),
    .me_start(me_start), .me_mb_x(me_mb_x), .me_mb_y(me_mb_y),
    .me_frame_addr(me_frame_addr), .me_ref_addr(me_ref_addr),
    .me_done(me_done), .me_mv_x(me_mv_x), .me_mv_y(me_mv_y), .me_sad(me_sad),
    .res_valid(res_valid), .res_ready(res_ready), .res_mb_idx(res_mb_idx),
    .res_mv_x(res_mv_x), .res_mv_y(res_mv_y), .res_sad(res_sad),
    .busy(busy), .frame_done(frame_done), .mb_count(mb_count)
  );

  always #5 clk = ~clk;

  // Engine model: done 5 cycles after start, released hold_cfg+1 cycles after start falls.
  logic [3:0] eng_cnt, eng_hcnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      me_done <= 1'b0; eng_cnt <= '0; eng_hcnt <= '0;
      me_mv_x <= '0; me_mv_y <= '0; me_sad <= '0;
    end else if (me_start && !me_done) begin
      if (eng_cnt == 4'd4) begin
        me_done <= 1'b1;
        eng_cnt <= '0;
        me_mv_x <= me_mb_x[9:4] + 6'd1;
        me_mv_y <= 6'd0 - me_mb_y[9:4] - 6'd1;
        me_sad  <= {me_mb_y[7:0], me_mb_x[7:0]} + 16'd1;
      end else begin
        eng_cnt <= eng_cnt + 4'd1;
      end
    end else if (!me_start && me_done) begin
      if (int'(eng_hcnt) >= hold_cfg) begin
        me_done  <= 1'b0;
        eng_hcnt <= '0;
      end else begin
        eng_hcnt <= eng_hcnt + 4'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0; prev_done = 1'b0; gap = 1000;
    end else begin
      if (res_valid && res_ready) pops.push_back({res_mb_idx, res_mv_x, res_mv_y, res_sad});
      if (frame_done) begin
        fd_cnt++;
        pops_at_done = pops.size();
      end
      if (me_start && !prev_start) begin
        starts.push_back({me_mb_x[15:0], me_mb_y[15:0]});
        if (prev_done || me_done) viol++;
        if (gap < min_gap) min_gap = gap;
      end
      gap = me_start ? 0 : gap + 1;
      prev_start = me_start;
      prev_done  = me_done;
    end
  end

  function automatic logic [36:0] exp_entry(input int i);
    logic [7:0] x, y;
    logic [5:0] mx, my;
    x  = 8'((i % 3) * 16);
    y  = 8'((i / 3) * 16);
    mx = 6'(i % 3 + 1);
    my = 6'd0 - 6'(i / 3) - 6'd1;
    return {9'(i), mx, my, {y, x} + 16'd1};
  endfunction

  function automatic logic [31:0] exp_pos(input int i);
    return {16'((i % 3) * 16), 16'((i / 3) * 16)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    pops.delete();
    starts.delete();
    fd_cnt = 0; viol = 0; min_gap = 1000;
  endtask

  task automatic go(input logic [31:0] fa, input logic [31:0] ra);
    frame_start_addr = fa;
    ref_start_addr   = ra;
    frame_go = 1'b1;
    step();
    frame_go = 1'b0;
  endtask

  task automatic wait_frame_done(input string name);
    for (int k = 0; k < 2000; k++) begin
      if (fd_cnt != 0) break;
      step();
    end
    checks++;
    if (fd_cnt == 0) begin
      errors++;
      $display("FAIL %s frame_done timeout: got no pulse, want 1", name);
    end
    step(); step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if ({me_start, busy, frame_done, res_valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl got start/busy/done/valid=%b want 0000",
               {me_start, busy, frame_done, res_valid});
    end
    checks++;
    if ({me_mb_x, me_mb_y, me_frame_addr, me_ref_addr} !== 128'd0) begin
      errors++;
      $display("FAIL reset_regs got x=%h y=%h fa=%h ra=%h want 0", me_mb_x, me_mb_y,
               me_frame_addr, me_ref_addr);
    end
    checks++;
    if ({res_mb_idx, res_mv_x, res_mv_y, res_sad, mb_count} !== 46'd0) begin
      errors++;
      $display("FAIL reset_res got idx=%0d sad=%h cnt=%0d want 0", res_mb_idx, res_sad, mb_count);
    end
  endtask

  task automatic test_raster();
    hold_cfg = 0; res_ready = 1'b1;
    clear_mon();
    go(32'hA000_0000, 32'hB000_0000);
    checks++;
    if (me_start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL raster_start got start=%b busy=%b want 1 1", me_start, busy);
    end
    checks++;
    if (me_frame_addr !== 32'hA000_0000 || me_ref_addr !== 32'hB000_0000) begin
      errors++;
      $display("FAIL raster_addr got %h/%h want a0000000/b0000000", me_frame_addr, me_ref_addr);
    end
    wait_frame_done("raster");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= starts.size() || starts[i] !== exp_pos(i)) begin
        errors++;
        $display("FAIL raster_pos%0d got %h want %h", i,
                 (i < starts.size()) ? starts[i] : 32'hx, exp_pos(i));
      end
      checks++;
      if (i >= pops.size() || pops[i] !== exp_entry(i)) begin
        errors++;
        $display("FAIL raster_res%0d got %h want %h", i,
                 (i < pops.size()) ? pops[i] : 37'hx, exp_entry(i));
      end
    end
    checks++;
    if (fd_cnt != 1 || pops_at_done != 6 || mb_count !== 9'd6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL raster_end got pulses=%0d pops=%0d cnt=%0d busy=%b want 1 6 6 0",
               fd_cnt, pops_at_done, mb_count, busy);
    end
    checks++;
    if (min_gap < 2 || viol != 0) begin
      errors++;
      $display("FAIL raster_gap got min_gap=%0d viol=%0d want >=2 0", min_gap, viol);
    end
  endtask

  task automatic test_handshake();
    hold_cfg = 3; res_ready = 1'b1;
    clear_mon();
    go(32'h10, 32'h20);
    wait_frame_done("handshake");
    checks++;
    if (viol != 0 || min_gap < 5 || starts.size() != 6 || pops.size() != 6) begin
      errors++;
      $display("FAIL handshake got viol=%0d gap=%0d starts=%0d pops=%0d want 0 >=5 6 6",
               viol, min_gap, starts.size(), pops.size());
    end
    hold_cfg = 0;
  endtask

  task automatic test_backpressure();
    hold_cfg = 0; res_ready = 1'b0;
    clear_mon();
    go(32'h100, 32'h200);
    for (int k = 0; k < 500; k++) begin
      if (mb_count == 9'd4 && me_start && me_done) break;
      step();
    end
    step(); step(); step();
    checks++;
    if (mb_count !== 9'd4 || me_start !== 1'b1 || me_done !== 1'b1 || res_mb_idx !== 9'd0) begin
      errors++;
      $display("FAIL bp_hold got cnt=%0d start=%b done=%b head=%0d want 4 1 1 0",
               mb_count, me_start, me_done, res_mb_idx);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    checks++;
    if (mb_count !== 9'd4 || me_start !== 1'b1 || res_mb_idx !== 9'd1) begin
      errors++;
      $display("FAIL bp_pop got cnt=%0d start=%b head=%0d want 4 1 1", mb_count, me_start,
               res_mb_idx);
    end
    step();
    checks++;
    if (mb_count !== 9'd5 || me_start !== 1'b0) begin
      errors++;
      $display("FAIL bp_push got cnt=%0d start=%b want 5 0", mb_count, me_start);
    end
    res_ready = 1'b1;
    wait_frame_done("bp");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= pops.size() || pops[i] !== exp_entry(i)) begin
        errors++;
        $display("FAIL bp_res%0d got %h want %h", i, (i < pops.size()) ? pops[i] : 37'hx,
                 exp_entry(i));
      end
    end
  endtask

  task automatic test_abort();
    hold_cfg = 0; res_ready = 1'b0;
    clear_mon();
    go(32'h300, 32'h400);
    for (int k = 0; k < 500; k++) begin
      if (mb_count == 9'd2 && me_start && me_done) break;
      step();
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (me_start !== 1'b0 || mb_count !== 9'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_stop got start=%b cnt=%0d busy=%b want 0 2 1", me_start, mb_count,
               busy);
    end
    for (int k = 0; k < 50; k++) begin
      if (!busy) break;
      step();
    end
    checks++;
    if (busy !== 1'b0 || me_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle got busy=%b done=%b want 0 0", busy, me_done);
    end
    res_ready = 1'b1;
    step(); step(); step(); step();
    checks++;
    if (pops.size() != 2 || res_valid !== 1'b0 || fd_cnt != 0) begin
      errors++;
      $display("FAIL abort_drain got pops=%0d valid=%b pulses=%0d want 2 0 0", pops.size(),
               res_valid, fd_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= pops.size() || pops[i] !== exp_entry(i)) begin
        errors++;
        $display("FAIL abort_res%0d got %h want %h", i, (i < pops.size()) ? pops[i] : 37'hx,
                 exp_entry(i));
      end
    end
  endtask

  task automatic test_async_reset();
    hold_cfg = 0; res_ready = 1'b1;
    clear_mon();
    go(32'h500, 32'h600);
    for (int k = 0; k < 500; k++) begin
      if (mb_count == 9'd3 && me_start) break;
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({me_start, busy, res_valid, mb_count, me_mb_x, me_mb_y, me_frame_addr, me_ref_addr}
        !== 140'd0) begin
      errors++;
      $display("FAIL areset got start=%b busy=%b cnt=%0d x=%h fa=%h want all 0", me_start,
               busy, mb_count, me_mb_x, me_frame_addr);
    end
    step();
    rst_n = 1'b1;
    step();
    clear_mon();
    go(32'h1000, 32'h8000);
    checks++;
    if (me_start !== 1'b1 || me_mb_x !== 32'd0 || me_mb_y !== 32'd0 || mb_count !== 9'd0) begin
      errors++;
      $display("FAIL restart_pos got start=%b x=%0d y=%0d cnt=%0d want 1 0 0 0", me_start,
               me_mb_x, me_mb_y, mb_count);
    end
    checks++;
    if (me_frame_addr !== 32'h1000 || me_ref_addr !== 32'h8000) begin
      errors++;
      $display("FAIL restart_addr got %h/%h want 1000/8000", me_frame_addr, me_ref_addr);
    end
    wait_frame_done("restart");
    checks++;
    if (pops.size() != 6 || pops[5] !== exp_entry(5)) begin
      errors++;
      $display("FAIL restart_res got n=%0d want 6", pops.size());
    end
  endtask

  task automatic test_go_busy();
    hold_cfg = 0; res_ready = 1'b1;
    clear_mon();
    go(32'h2000, 32'h3000);
    for (int k = 0; k < 500; k++) begin
      if (mb_count == 9'd2) break;
      step();
    end
    go(32'hDEAD_0000, 32'hBEEF_0000);
    checks++;
    if (me_frame_addr !== 32'h2000 || me_ref_addr !== 32'h3000) begin
      errors++;
      $display("FAIL gobusy_addr got %h/%h want 2000/3000", me_frame_addr, me_ref_addr);
    end
    wait_frame_done("gobusy");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= starts.size() || starts[i] !== exp_pos(i) || i >= pops.size() ||
          pops[i] !== exp_entry(i)) begin
        errors++;
        $display("FAIL gobusy_mb%0d got pos=%h res=%h want %h %h", i,
                 (i < starts.size()) ? starts[i] : 32'hx, (i < pops.size()) ? pops[i] : 37'hx,
                 exp_pos(i), exp_entry(i));
      end
    end
    checks++;
    if (fd_cnt != 1 || starts.size() != 6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL gobusy_end got pulses=%0d starts=%0d busy=%b want 1 6 0", fd_cnt,
               starts.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_handshake();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_go_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
